// File: rtl/inst_sram_axi_rd_bridge.sv
// Instruction-side SRAM-like responder that turns each accepted fetch into a
// single-beat AXI read and returns the data in request order.
module inst_sram_axi_rd_bridge #(
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter logic [3:0]  AXI_ID          = 4'h0
) (
  input  logic        clk,
  input  logic        resetn,
  // SRAM-like fetch interface
  input  logic        inst_sram_req,
  input  logic        inst_sram_wr,
  input  logic [1:0]  inst_sram_size,
  input  logic [3:0]  inst_sram_wstrb,
  input  logic [31:0] inst_sram_addr,
  input  logic [31:0] inst_sram_wdata,
  output logic        inst_sram_addr_ok,
  output logic        inst_sram_data_ok,
  output logic [31:0] inst_sram_rdata,
  // AXI read address channel
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [7:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic [1:0]  arlock,
  output logic [3:0]  arcache,
  output logic [2:0]  arprot,
  output logic        arvalid,
  input  logic        arready,
  // AXI read data channel
  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready
);

  localparam logic [2:0] MaxOut = 3'(MAX_OUTSTANDING);

  typedef enum logic [0:0] {ArIdle, ArBusy} ar_state_e;

  ar_state_e   ar_state_q, ar_state_d;
  logic [31:0] araddr_q, araddr_d;
  logic [1:0]  arsize_q, arsize_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        data_ok_q;
  logic [31:0] rdata_q;
  logic        accept;
  logic        r_hs;

  // Single ID and in-order return, so rid/rresp/rlast carry no extra information.
  logic unused_inputs;
  assign unused_inputs = ^{inst_sram_wstrb, inst_sram_wdata, rid, rresp, rlast};

  assign accept = resetn & inst_sram_req & ~inst_sram_wr & (ar_state_q == ArIdle) &
                  (cnt_q < MaxOut);
  assign rready = resetn & (cnt_q != 3'd0);
  assign r_hs   = rvalid & rready;

  always_comb begin
    ar_state_d = ar_state_q;
    araddr_d   = araddr_q;
    arsize_d   = arsize_q;
    unique case (ar_state_q)
      ArIdle: begin
        if (accept) begin
          araddr_d   = inst_sram_addr;
          arsize_d   = inst_sram_size;
          ar_state_d = ArBusy;
        end
      end
      ArBusy: begin
        if (arready) begin
          ar_state_d = ArIdle;
        end
      end
      default: ar_state_d = ArIdle;
    endcase
  end

  always_comb begin
    cnt_d = cnt_q;
    unique case ({accept, r_hs})
      2'b10:   cnt_d = cnt_q + 3'd1;
      2'b01:   cnt_d = cnt_q - 3'd1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ar_state_q <= ArIdle;
      araddr_q   <= 32'h0;
      arsize_q   <= 2'b00;
      cnt_q      <= 3'd0;
      data_ok_q  <= 1'b0;
      rdata_q    <= 32'h0;
    end else begin
      ar_state_q <= ar_state_d;
      araddr_q   <= araddr_d;
      arsize_q   <= arsize_d;
      cnt_q      <= cnt_d;
      data_ok_q  <= r_hs;
      if (r_hs) begin
        rdata_q <= rdata;
      end
    end
  end

  assign inst_sram_addr_ok = accept;
  assign inst_sram_data_ok = data_ok_q;
  assign inst_sram_rdata   = rdata_q;

  assign arvalid = (ar_state_q == ArBusy);
  assign araddr  = araddr_q;
  assign arsize  = {1'b0, arsize_q};
  assign arid    = AXI_ID;
  assign arlen   = 8'h00;
  assign arburst = 2'b01;
  assign arlock  = 2'b00;
  assign arcache = 4'h0;
  assign arprot  = 3'b000;

endmodule

// File: tb/tb_inst_sram_axi_rd_bridge.sv
// Bench for inst_sram_axi_rd_bridge: bench-side AXI slave plus an in-order
// scoreboard of expected AR addresses and returned instructions.
module tb_inst_sram_axi_rd_bridge;

  localparam logic [3:0] Id = 4'h3;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        inst_sram_req = 1'b0;
  logic        inst_sram_wr = 1'b0;
  logic [1:0]  inst_sram_size = 2'b10;
  logic [3:0]  inst_sram_wstrb = 4'h0;
  logic [31:0] inst_sram_addr = 32'h0;
  logic [31:0] inst_sram_wdata = 32'h0;
  logic        inst_sram_addr_ok;
  logic        inst_sram_data_ok;
  logic [31:0] inst_sram_rdata;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic [1:0]  arlock;
  logic [3:0]  arcache;
  logic [2:0]  arprot;
  logic        arvalid;
  logic        arready = 1'b0;
  logic [3:0]  rid = Id;
  logic [31:0] rdata = 32'h0;
  logic [1:0]  rresp = 2'b00;
  logic        rlast = 1'b0;
  logic        rvalid = 1'b0;
  logic        rready;

  always #5 clk = ~clk;

  inst_sram_axi_rd_bridge #(
    .MAX_OUTSTANDING(2),
    .AXI_ID         (Id)
  ) dut (
    .clk              (clk),
    .resetn           (resetn),
    .inst_sram_req    (inst_sram_req),
    .inst_sram_wr     (inst_sram_wr),
    .inst_sram_size   (inst_sram_size),
    .inst_sram_wstrb  (inst_sram_wstrb),
    .inst_sram_addr   (inst_sram_addr),
    .inst_sram_wdata  (inst_sram_wdata),
    .inst_sram_addr_ok(inst_sram_addr_ok),
    .inst_sram_data_ok(inst_sram_data_ok),
    .inst_sram_rdata  (inst_sram_rdata),
    .arid             (arid),
    .araddr           (araddr),
    .arlen            (arlen),
    .arsize           (arsize),
    .arburst          (arburst),
    .arlock           (arlock),
    .arcache          (arcache),
    .arprot           (arprot),
    .arvalid          (arvalid),
    .arready          (arready),
    .rid              (rid),
    .rdata            (rdata),
    .rresp            (rresp),
    .rlast            (rlast),
    .rvalid           (rvalid),
    .rready           (rready)
  );

  typedef struct {
    logic [31:0] addr;
    logic        wr;
    logic [1:0]  size;
    int          stall;
    int          hold;
    logic        exp_acc;
  } vec_t;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int dok_n = 0;

  logic [31:0] ar_q[$];
  logic [1:0]  sz_q[$];
  logic [31:0] data_q[$];
  logic [31:0] r_pend[$];
  int ar_stall = 0;
  int r_hold   = 0;
  bit r_block  = 1'b0;
  bit stray    = 1'b0;
  bit dok_due  = 1'b0;

  bit          s_addr_ok, s_arvalid, s_rhs, s_data_ok, s_rready;
  logic [31:0] s_araddr, s_rdata;

  function automatic logic [31:0] mem_f(input logic [31:0] a);
    return (a == 32'h1C00_0000) ? 32'h02C0_0000 : (a ^ 32'hA5A5_5A5A);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock: drive slave outputs at the falling edge, sample 1ns later,
  // then return at the next falling edge.
  task automatic cycle();
    arready = (ar_stall == 0);
    rvalid  = 1'b0;
    rdata   = 32'h0;
    rresp   = 2'b00;
    rlast   = 1'b0;
    rid     = Id;
    if (r_pend.size() != 0 && !r_block && r_hold == 0) begin
      rvalid = 1'b1;
      rdata  = mem_f(r_pend[0]);
      rresp  = 2'($urandom_range(0, 3));
      rlast  = 1'b1;
    end else if (stray && r_pend.size() == 0) begin
      rvalid = 1'b1;
      rdata  = 32'hDEAD_BEEF;
      rlast  = 1'b1;
    end
    #1;
    s_addr_ok = inst_sram_addr_ok;
    s_arvalid = arvalid;
    s_araddr  = araddr;
    s_rready  = rready;
    s_rhs     = rvalid && rready;
    s_data_ok = inst_sram_data_ok;
    s_rdata   = inst_sram_rdata;

    if (inst_sram_data_ok || dok_due) chk("data_ok_pulse", inst_sram_data_ok, dok_due);
    if (inst_sram_data_ok) begin
      dok_n++;
      if (data_q.size() != 0) chk("rdata_order", inst_sram_rdata, data_q.pop_front());
      else chk("spurious_data_ok", 1, 0);
    end

    if (arvalid) begin
      chk("addr_ok_in_busy", inst_sram_addr_ok, 0);
      if (ar_q.size() == 0) begin
        chk("spurious_arvalid", 1, 0);
      end else begin
        chk("araddr", araddr, ar_q[0]);
        chk("arsize", 32'(arsize), 32'({1'b0, sz_q[0]}));
        if (arready) begin
          chk("ar_consts", {arid, arlen, arburst, arlock, arcache, arprot},
              {Id, 8'h00, 2'b01, 2'b00, 4'h0, 3'b000});
          r_pend.push_back(ar_q.pop_front());
          void'(sz_q.pop_front());
        end else begin
          ar_stall--;
        end
      end
    end

    if (inst_sram_addr_ok) begin
      ar_q.push_back(inst_sram_addr);
      sz_q.push_back(inst_sram_size);
      data_q.push_back(mem_f(inst_sram_addr));
    end

    if (rvalid && rready) begin
      if (r_pend.size() == 0) chk("stray_rvalid_acked", 1, 0);
      else void'(r_pend.pop_front());
    end else if (r_pend.size() != 0 && !r_block && r_hold > 0) begin
      r_hold--;
    end
    dok_due = rvalid && rready;
    cyc++;
    @(negedge clk);
  endtask

  task automatic issue(input logic [31:0] addr, input logic wr, input int bound,
                       output bit ok);
    inst_sram_req  = 1'b1;
    inst_sram_wr   = wr;
    inst_sram_addr = addr;
    ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      cycle();
      if (s_addr_ok) begin
        ok = 1'b1;
        break;
      end
    end
    inst_sram_req = 1'b0;
    inst_sram_wr  = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 60; i++) begin
      if (ar_q.size() == 0 && r_pend.size() == 0 && data_q.size() == 0 && !dok_due) break;
      cycle();
    end
    chk("drain_outstanding", 32'(ar_q.size() + r_pend.size() + data_q.size()), 0);
  endtask

  vec_t vecs[6];

  initial begin
    bit ok;
    int d0;
    int hs_cyc;
    int acc_cyc;

    vecs[0] = '{32'h1C00_1000, 1'b0, 2'b10, 0, 0, 1'b1};
    vecs[1] = '{32'h1C00_1004, 1'b0, 2'b10, 2, 3, 1'b1};
    vecs[2] = '{32'h1C00_1008, 1'b1, 2'b10, 0, 0, 1'b0};
    vecs[3] = '{32'h0000_0000, 1'b0, 2'b00, 1, 0, 1'b1};
    vecs[4] = '{32'hFFFF_FFFC, 1'b0, 2'b01, 0, 5, 1'b1};
    vecs[5] = '{32'h8000_0000, 1'b1, 2'b10, 0, 0, 1'b0};

    // Reset state, with a request already pending on the input.
    inst_sram_req  = 1'b1;
    inst_sram_addr = 32'h1C00_0040;
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("rst_addr_ok", inst_sram_addr_ok, 0);
    chk("rst_arvalid", arvalid, 0);
    chk("rst_rready", rready, 0);
    chk("rst_data_ok", inst_sram_data_ok, 0);
    chk("rst_rdata", inst_sram_rdata, 0);
    inst_sram_req = 1'b0;
    resetn = 1'b1;
    @(negedge clk);

    // Single fetch, minimum latency.
    issue(32'h1C00_0000, 1'b0, 1, ok);
    chk("t1_addr_ok_T", ok, 1);
    cycle();
    chk("t1_arvalid_T1", s_arvalid, 1);
    chk("t1_araddr_T1", s_araddr, 32'h1C00_0000);
    cycle();
    chk("t1_rhs_T2", s_rhs, 1);
    cycle();
    chk("t1_data_ok_T3", s_data_ok, 1);
    chk("t1_rdata_T3", s_rdata, 32'h02C0_0000);
    drain();

    // Table of single requests with varied back-pressure.
    foreach (vecs[k]) begin
      d0 = dok_n;
      ar_stall = vecs[k].stall;
      r_hold   = vecs[k].hold;
      inst_sram_size = vecs[k].size;
      issue(vecs[k].addr, vecs[k].wr, 4, ok);
      chk("vec_accept", ok, vecs[k].exp_acc);
      drain();
      chk("vec_data_ok_count", 32'(dok_n - d0), 32'(vecs[k].exp_acc));
      r_hold = 0;
      ar_stall = 0;
    end
    inst_sram_size = 2'b10;

    // arready held low for 5 cycles while another request waits.
    d0 = dok_n;
    ar_stall = 5;
    issue(32'h1C00_0100, 1'b0, 2, ok);
    chk("t2_accept", ok, 1);
    inst_sram_req  = 1'b1;
    inst_sram_addr = 32'h1C00_0200;
    for (int i = 0; i < 5; i++) begin
      cycle();
      chk("t2_arvalid_held", s_arvalid, 1);
      chk("t2_no_accept", s_addr_ok, 0);
    end
    inst_sram_req = 1'b0;
    drain();
    chk("t2_one_data_ok", 32'(dok_n - d0), 1);

    // Outstanding limit: third request waits for the first R handshake.
    r_block = 1'b1;
    issue(32'h1C00_0300, 1'b0, 2, ok);
    chk("t3_accept_a", ok, 1);
    issue(32'h1C00_0304, 1'b0, 4, ok);
    chk("t3_accept_b", ok, 1);
    inst_sram_req  = 1'b1;
    inst_sram_addr = 32'h1C00_0308;
    for (int i = 0; i < 4; i++) begin
      cycle();
      chk("t3_full_block", s_addr_ok, 0);
    end
    r_block = 1'b0;
    hs_cyc  = -1;
    acc_cyc = -100;
    for (int i = 0; i < 10; i++) begin
      cycle();
      if (s_rhs && hs_cyc < 0) hs_cyc = cyc - 1;
      if (s_addr_ok) begin
        acc_cyc = cyc - 1;
        break;
      end
    end
    inst_sram_req = 1'b0;
    chk("t3_accept_after_hs", 32'(acc_cyc), 32'(hs_cyc + 1));
    drain();

    // Accept and R handshake in the same cycle with one outstanding.
    r_block = 1'b1;
    issue(32'h1C00_0400, 1'b0, 2, ok);
    chk("t4_accept_a", ok, 1);
    cycle();
    inst_sram_req  = 1'b1;
    inst_sram_addr = 32'h1C00_0404;
    r_block = 1'b0;
    cycle();
    chk("t4_same_cycle_acc", s_addr_ok, 1);
    chk("t4_same_cycle_rhs", s_rhs, 1);
    inst_sram_req = 1'b0;
    r_block = 1'b1;
    cycle();
    cycle();
    chk("t4_rready_cnt1", s_rready, 1);
    issue(32'h1C00_0408, 1'b0, 3, ok);
    chk("t4_accept_c", ok, 1);
    r_block = 1'b0;
    drain();
    cycle();
    chk("t4_rready_idle", s_rready, 0);

    // Write requests are never accepted.
    inst_sram_req  = 1'b1;
    inst_sram_wr   = 1'b1;
    inst_sram_addr = 32'h1C00_0500;
    for (int i = 0; i < 6; i++) begin
      cycle();
      chk("t5_wr_addr_ok", s_addr_ok, 0);
      chk("t5_wr_arvalid", s_arvalid, 0);
    end
    inst_sram_req = 1'b0;
    inst_sram_wr  = 1'b0;

    // Stray rvalid with nothing outstanding stays unacknowledged.
    stray = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("stray_rready", s_rready, 0);
    end
    stray = 1'b0;
    cycle();
    chk("stray_no_data_ok", s_data_ok, 0);

    // Reset while the AR is stalled with one outstanding.
    ar_stall = 10;
    issue(32'h1C00_0600, 1'b0, 2, ok);
    chk("t6_accept", ok, 1);
    cycle();
    cycle();
    chk("t6_busy_before_rst", s_arvalid, 1);
    inst_sram_req  = 1'b1;
    inst_sram_addr = 32'h1C00_0700;
    #2;
    resetn = 1'b0;
    #1;
    chk("t6_rst_arvalid", arvalid, 0);
    chk("t6_rst_rready", rready, 0);
    chk("t6_rst_addr_ok", inst_sram_addr_ok, 0);
    chk("t6_rst_rdata", inst_sram_rdata, 0);
    ar_q.delete();
    sz_q.delete();
    data_q.delete();
    r_pend.delete();
    ar_stall = 0;
    dok_due  = 1'b0;
    @(negedge clk);
    #1;
    chk("t6_rst_hold_addr_ok", inst_sram_addr_ok, 0);
    @(negedge clk);
    inst_sram_req = 1'b0;
    resetn = 1'b1;
    d0 = dok_n;
    issue(32'h1C00_0700, 1'b0, 2, ok);
    chk("t6_accept_after_rst", ok, 1);
    drain();
    chk("t6_data_ok_after_rst", 32'(dok_n - d0), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
